regfile_2r1w_sb: RTL and testbench
==================================

Name: regfile_2r1w_sb

Overview:
- Integer register file for the 32-bit RISC-V datapath: two combinational read ports for decode (rs1/rs2) and one synchronous write port for writeback (rd).
- Includes a per-register busy scoreboard. Decode marks a destination pending at issue; writeback clears it.
- Produces a stall when a source operand is still pending.
- Sits between the decode stage and the writeback mux.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- AW, 5, address width; must satisfy 2**AW == NREGS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rs1_data  output  XLEN  read port 1 data (combinational).
- rs2_data  output  XLEN  read port 2 data (combinational).
- we  input  1  writeback enable.
- rd_addr  input  AW  writeback register address.
- rd_data  input  XLEN  writeback data.
- issue_en  input  1  decode issued an instruction that will write issue_rd.
- issue_rd  input  AW  destination register of the issued instruction.
- rs1_busy  output  1  rs1 operand pending (combinational).
- rs2_busy  output  1  rs2 operand pending (combinational).
- stall  output  1  rs1_busy | rs2_busy.

Behaviour:
- Storage:
  - regs[1..NREGS-1] are XLEN-bit state; busy[1..NREGS-1] are 1-bit state.
  - Index 0 has no storage.
- Reset:
  - When rst=1 at a rising edge, all regs clear to 0 and all busy bits clear to 0.
  - rst has priority over we and issue_en in the same cycle.
  - A reset asserted mid-operation discards all pending writes and busy state.
  - Outputs after reset: rs*_data=0, rs*_busy=0, stall=0.
- Write:
  - At a rising edge with rst=0, we=1 and rd_addr!=0: regs[rd_addr] <= rd_data.
  - Writes to x0 are silently ignored.
- Read:
  - rsN_data = 0 if rsN_addr==0.
  - Otherwise rsN_data = regs[rsN_addr], subject to the bypass rule under Optional Feature.
  - Zero-cycle combinational latency; both ports are independent and may address the same register.
- Scoreboard update, each rising edge with rst=0:
  - If we=1 and rd_addr!=0: busy[rd_addr] <= 0.
  - If issue_en=1 and issue_rd!=0: busy[issue_rd] <= 1.
  - If both target the same register in the same cycle, set wins: busy stays 1, because a new producer was issued.
  - issue_en to x0 has no effect; busy for x0 is always 0.
  - Re-issue to an already-busy register leaves it busy. There is no counting: a single writeback clears it.
  - A writeback to a register that is not busy is legal; busy stays 0.
- Busy outputs:
  - rsN_busy = 0 if rsN_addr==0.
  - Otherwise rsN_busy = busy[rsN_addr], subject to the early-clear rule under Optional Feature.
  - stall = rs1_busy | rs2_busy, purely combinational.
  - Issue in cycle N makes busy visible from cycle N+1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass: if we=1, rd_addr!=0 and rd_addr==rsN_addr, then rsN_data = rd_data in the same cycle.
  - Early clear: in that same case rsN_busy = 0, even though busy[rsN_addr] is still 1 until the edge.
- Undefined:
  - rsN_data always reflects stored regs, so new data is visible the cycle after the write.
  - rsN_busy = busy[rsN_addr] unmodified, so a dependent instruction stalls one cycle longer.
- Scoreboard state update is identical in both builds.

Test Plan:
- Reset: write 0xDEADBEEF to x5, then assert rst for 1 cycle with we=1 and issue_en=1 to x5 -> rs1_addr=5 gives rs1_data=0, rs1_busy=0, stall=0.
- Write/read: we=1, rd_addr=7, rd_data=0x12345678; next cycle rs1_addr=7, rs2_addr=7 -> both ports read 0x12345678.
- x0: we=1, rd_addr=0, rd_data=0xFFFFFFFF, and issue_en=1, issue_rd=0 -> rs1_addr=0 gives rs1_data=0, rs1_busy=0 every cycle.
- Scoreboard: issue_en=1, issue_rd=3 at cycle N; rs2_addr=3 -> rs2_busy=1 and stall=1 from N+1. At N+3, we=1, rd_addr=3, rd_data=0xA5A5A5A5:
  - With REGFILE_BYPASS_EN: stall=0 and rs2_data=0xA5A5A5A5 at N+3.
  - Without it: stall stays 1 at N+3; stall=0 and rs2_data=0xA5A5A5A5 at N+4.
- Simultaneous set/clear: x9 busy; in one cycle we=1, rd_addr=9 and issue_en=1, issue_rd=9 -> next cycle rs1_addr=9 gives rs1_busy=1 and regs[9] updated with rd_data.
- Dual-port independence: write x1=0x11, x2=0x22; read rs1_addr=2, rs2_addr=1 -> rs1_data=0x22, rs2_data=0x11; a busy x2 and idle x1 give rs1_busy=1, rs2_busy=0, stall=1.

Source files
------------

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: RV32 integer register file with two combinational read
// ports, one synchronous write port and a per-register busy scoreboard that
// raises a stall when a source operand is still pending.
//
// Optional build macro: REGFILE_BYPASS_EN
//   defined   -> a writeback in the current cycle is forwarded to matching
//                read ports, and their busy flags clear early.
//   undefined -> reads and busy flags reflect stored state only.
// The scoreboard state update is the same in both builds.
// Parameters must satisfy 2**AW == NREGS; x0 reads as zero and is never busy.

module regfile_2r1w_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            issue_en,
    input  logic [AW-1:0]   issue_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall
);

    // Architectural state; index 0 has no storage.
    logic [XLEN-1:0]  regs_q [1:NREGS-1];
    logic [XLEN-1:0]  regs_d [1:NREGS-1];
    logic [NREGS-1:1] busy_q;
    logic [NREGS-1:1] busy_d;

    logic wb_valid;
    logic issue_valid;

    assign wb_valid    = we && (rd_addr != '0);
    assign issue_valid = issue_en && (issue_rd != '0);

    // Next-state for register contents and busy bits: reset, write, then issue.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        regs_d = regs_q;
        busy_d = busy_q;
        if (rst) begin
            // NOTE: the whole array is cleared on reset because software is
            // allowed to observe registers before writing them; this costs a
            // reset mux per bit, so it is not done for generic memories.
            for (int i = 1; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
            busy_d = '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_valid && (rd_addr == AW'(i))) begin
                    regs_d[i] = rd_data;
                    busy_d[i] = 1'b0;
                end
                // Issue is evaluated after writeback so a new producer wins.
                if (issue_valid && (issue_rd == AW'(i))) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    // State register: capture next-state on every rising edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        regs_q <= regs_d;
        busy_q <= busy_d;
    end

    // Read port 1: zero for x0, stored value otherwise, optional forwarding.
    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (rs1_addr != '0) begin
            rs1_data = regs_q[rs1_addr];
            rs1_busy = busy_q[rs1_addr];
`ifdef REGFILE_BYPASS_EN
            if (wb_valid && (rd_addr == rs1_addr)) begin
                rs1_data = rd_data;
                rs1_busy = 1'b0;
            end
`endif
        end
    end

    // Read port 2: zero for x0, stored value otherwise, optional forwarding.
    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (rs2_addr != '0) begin
            rs2_data = regs_q[rs2_addr];
            rs2_busy = busy_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (wb_valid && (rd_addr == rs2_addr)) begin
                rs2_data = rd_data;
                rs2_busy = 1'b0;
            end
`endif
        end
    end

    assign stall = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Self-checking bench for regfile_2r1w_sb: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a plain
// array model of the register file and scoreboard.

module tb_regfile_2r1w_sb;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr, rd_addr, issue_rd;
    logic [XLEN-1:0] rs1_data, rs2_data, rd_data;
    logic            we, issue_en;
    logic            rs1_busy, rs2_busy, stall;

    int checks = 0;
    int errors = 0;
    bit model_on = 1'b0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    regfile_2r1w_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .we       (we),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] actual,
                         input logic [XLEN-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // Expected read data seen by a port addressing 'a' this cycle.
    function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && rd_addr != 0 && rd_addr == a) return rd_data;
`endif
        return m_regs[a];
    endfunction

    // Expected busy flag seen by a port addressing 'a' this cycle.
    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we && rd_addr != 0 && rd_addr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    // Model state update at each rising edge from the inputs held over it.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (we && rd_addr != 0) begin
                m_regs[rd_addr] = rd_data;
                m_busy[rd_addr] = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
    end

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (model_on) begin
            logic eb1, eb2;
            eb1 = exp_busy(rs1_addr);
            eb2 = exp_busy(rs2_addr);
            check("model_rs1_data", rs1_data, exp_data(rs1_addr));
            check("model_rs2_data", rs2_data, exp_data(rs2_addr));
            check("model_rs1_busy", {31'b0, rs1_busy}, {31'b0, eb1});
            check("model_rs2_busy", {31'b0, rs2_busy}, {31'b0, eb2});
            check("model_stall", {31'b0, stall}, {31'b0, eb1 | eb2});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; issue_en = 1'b0; rst = 1'b0;
        rd_addr = '0; rd_data = '0; issue_rd = '0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; issue_en = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; issue_rd = '0; rd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_on = 1'b1;

        // Reset clears data and busy, and overrides a same-cycle write/issue.
        we = 1'b1; rd_addr = 5; rd_data = 32'hDEADBEEF;
        tick();
        rst = 1'b1; issue_en = 1'b1; issue_rd = 5; rs1_addr = 5;
        @(negedge clk);
        check("pre_rst_x5", rs1_data, 32'hDEADBEEF);
        tick();
        idle();
        @(negedge clk);
        check("rst_data", rs1_data, 32'h0);
        check("rst_busy", {31'b0, rs1_busy}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);

        // Write then read the same register on both ports.
        tick();
        we = 1'b1; rd_addr = 7; rd_data = 32'h12345678;
        tick();
        idle(); rs1_addr = 7; rs2_addr = 7;
        @(negedge clk);
        check("wr_rd_p1", rs1_data, 32'h12345678);
        check("wr_rd_p2", rs2_data, 32'h12345678);

        // x0 ignores writes and issues.
        tick();
        we = 1'b1; rd_addr = 0; rd_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_rd = 0; rs1_addr = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("x0_data", rs1_data, 32'h0);
            check("x0_busy", {31'b0, rs1_busy}, 32'h0);
            tick();
        end
        idle();
        @(negedge clk);
        check("x0_data_after", rs1_data, 32'h0);

        // Scoreboard on x3: issue at N, writeback at N+3.
        tick();
        rs1_addr = 0; rs2_addr = 3; issue_en = 1'b1; issue_rd = 3;
        @(negedge clk);
        check("sb_n_busy", {31'b0, rs2_busy}, 32'h0);
        tick();
        idle();
        @(negedge clk);
        check("sb_n1_busy", {31'b0, rs2_busy}, 32'h1);
        check("sb_n1_stall", {31'b0, stall}, 32'h1);
        tick();
        @(negedge clk);
        check("sb_n2_stall", {31'b0, stall}, 32'h1);
        tick();
        we = 1'b1; rd_addr = 3; rd_data = 32'hA5A5A5A5;
        @(negedge clk);
`ifdef REGFILE_BYPASS_EN
        check("sb_n3_stall", {31'b0, stall}, 32'h0);
        check("sb_n3_data", rs2_data, 32'hA5A5A5A5);
`else
        check("sb_n3_stall", {31'b0, stall}, 32'h1);
        check("sb_n3_data", rs2_data, 32'h0);
`endif
        tick();
        idle();
        @(negedge clk);
        check("sb_n4_stall", {31'b0, stall}, 32'h0);
        check("sb_n4_data", rs2_data, 32'hA5A5A5A5);

        // Simultaneous set and clear on x9: set wins, data still written.
        tick();
        rs2_addr = 0; issue_en = 1'b1; issue_rd = 9;
        tick();
        idle();
        we = 1'b1; rd_addr = 9; rd_data = 32'h99990000;
        issue_en = 1'b1; issue_rd = 9; rs1_addr = 9;
        tick();
        idle();
        @(negedge clk);
        check("setclr_busy", {31'b0, rs1_busy}, 32'h1);
        check("setclr_data", rs1_data, 32'h99990000);
        we = 1'b1; rd_addr = 9; rd_data = 32'h99990001;
        tick();
        idle();
        @(negedge clk);
        check("setclr_cleared", {31'b0, rs1_busy}, 32'h0);

        // Dual-port independence with one busy source.
        we = 1'b1; rd_addr = 1; rd_data = 32'h11;
        tick();
        rd_addr = 2; rd_data = 32'h22;
        tick();
        idle(); issue_en = 1'b1; issue_rd = 2;
        tick();
        idle(); rs1_addr = 2; rs2_addr = 1;
        @(negedge clk);
        check("dp_rs1_data", rs1_data, 32'h22);
        check("dp_rs2_data", rs2_data, 32'h11);
        check("dp_rs1_busy", {31'b0, rs1_busy}, 32'h1);
        check("dp_rs2_busy", {31'b0, rs2_busy}, 32'h0);
        check("dp_stall", {31'b0, stall}, 32'h1);

        // Randomized traffic; narrow address range half the time for collisions.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if ($urandom_range(0, 1) == 0) begin
                rs1_addr = AW'($urandom_range(0, 7));
                rs2_addr = AW'($urandom_range(0, 7));
                rd_addr  = AW'($urandom_range(0, 7));
                issue_rd = AW'($urandom_range(0, 7));
            end else begin
                rs1_addr = AW'($urandom);
                rs2_addr = AW'($urandom);
                rd_addr  = AW'($urandom);
                issue_rd = AW'($urandom);
            end
            rd_data  = $urandom;
            we       = ($urandom_range(0, 1) == 1);
            issue_en = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 127) == 0);
        end
        tick();
        idle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
